div_share_sched: RTL and testbench
==================================

# div_share_sched

Scheduler that time-shares one sequential divider (the `divider_32_21` core: `start` pulse in, `quotient` plus `qv` pulse out) between two requesters. It sits between the centroid moment accumulators and a single divider instance. Requester 0 serves x (m10/m00) and requester 1 serves y (m01/m00), which halves divider area per frame. It also handles arbitration, divide-by-zero bypass, and divider-timeout recovery.

## Interface
- `DW_N`, 32: dividend width
- `DW_D`, 22: divisor width
- `QW`, 32: quotient width
- `TIMEOUT`, 63: maximum WAIT cycles for `div_qv` before abort (≥1)

- `clk` in 1: sole clock, rising edge
- `rst` in 1: asynchronous, active-low reset
- `start0` / `start1` in 1: one-cycle request pulse from requester 0 / 1
- `dividend0` / `dividend1` in DW_N: operand, sampled only on an accepted start
- `divisor0` / `divisor1` in DW_D: operand, sampled only on an accepted start
- `busy0` / `busy1` out 1: request pending (accepted, not yet granted)
- `ack0` / `ack1` out 1: one-cycle result strobe
- `quot0` / `quot1` out QW: result, held until next ack of same requester
- `err0` / `err1` out 1: qualifies ack; 1 = divisor zero or timeout; held with quot
- `div_start` out 1: one-cycle start to divider
- `div_dividend` out DW_N, `div_divisor` out DW_D: operands, stable from ISSUE through WAIT
- `div_quotient` in QW, `div_qv` in 1: divider result and valid pulse

## Operation
- Per requester N: start accepted iff `pendingN==0`. Accept latches operands into opN regs and sets `pendingN`. Start while pending is ignored; opN unchanged.
- Accept is allowed while the same requester is in service. This queues one further request.
- `busyN = pendingN`.
- FSM states IDLE, ISSUE, WAIT, DONE:
  - IDLE: if any pending, grant by round-robin (`last` pointer; priority to requester ≠ `last`; `last` resets to 1, so requester 0 wins first tie). On grant, clear `pendingN`, copy opN to `div_dividend`/`div_divisor`, record id. If divisor==0, set result=0, err=1, go DONE. Else go ISSUE.
  - ISSUE: `div_start`=1 for this cycle only; timer←0; go WAIT.
  - WAIT: if `div_qv`, result←`div_quotient`, err←0, go DONE. Else if timer==TIMEOUT, result←0, err←1, go DONE. Else timer++.
  - DONE: `ackN`=1 for granted id; `quotN`/`errN` updated at entry; `last`←id; go IDLE.
- `div_qv` outside WAIT is ignored: late qv after timeout, spurious qv in IDLE/ISSUE/DONE.
- `div_quotient` passes through at full QW; no truncation. Consumer slices [10:0] for pixel coordinates.

## Timing
- Reset values: all outputs 0, pending 0, `last`=1, FSM IDLE, timer 0.
- Reset mid-operation aborts the operation: no ack, divider result discarded.
- Start in cycle 0 → `busyN`=1 in cycle 1 → grant edge at end of cycle 1 → `div_start`=1 in cycle 2 → WAIT from cycle 3.
- `div_qv` in cycle k (k≥3) → `ackN` in cycle k+1.
- Divisor zero: start in cycle 0 → ack in cycle 2, no `div_start`.
- Timeout: `div_start` in cycle 2, no qv → ack with err in cycle 4+TIMEOUT.
- Both starts in the same cycle: both busy; service is serial. The second `div_start` comes 2 cycles after the first ack (DONE→IDLE→ISSUE).
- Throughput: one division per (divider latency + 3) cycles.

## Test plan
- Reset, start0 with 1000/10, divider model latency 8 (qv 8 cycles after div_start): ack0 exactly 9 cycles after div_start; quot0=100; err0=0; busy0 low from cycle 2.
- start0 and start1 in the same cycle (640/64 and 1280/64): requester 0 served first, ack0 with quot0=10. Then div_start for requester 1; ack1 with quot1=20. `last` alternates on the next tie.
- start1 with divisor 0: ack1 in cycle 2, quot1=0, err1=1, div_start never asserted.
- TIMEOUT=4, divider never returns qv: ack0 at cycle 8 with err0=1. A qv injected 2 cycles later is ignored and produces no ack.
- start0 during its own WAIT with new operands: busy0=1; a third start0 while busy is ignored. Queued request served next with the second operands.
- Assert rst low during WAIT: outputs 0 immediately; pending cleared. After release, no ack appears; a fresh start0 completes normally.

Source files
------------

// File: rtl/div_share_sched.sv
// div_share_sched
// Time-shares one sequential divider between two requesters (0 = x, 1 = y).
// Each requester can queue one request. Grants alternate round-robin on ties.
// A zero divisor is answered directly without starting the divider. A divider
// that never raises qv is abandoned after TIMEOUT wait cycles.
//
// Ports
//   clk, rst (async, active low)
//   start0/1, dividend0/1, divisor0/1    requester inputs
//   busy0/1                              request queued, not yet granted
//   ack0/1, quot0/1, err0/1              result strobe, held result, error flag
//   div_start, div_dividend, div_divisor divider request side
//   div_quotient, div_qv                 divider result side
//
// state  | meaning
// IDLE   | arbitrate pending requests; zero divisor goes straight to DONE
// ISSUE  | one-cycle div_start, clear the wait timer
// WAIT   | wait for div_qv, or give up when the timer reaches TIMEOUT
// DONE   | one-cycle ack to the granted requester, update round-robin pointer
module div_share_sched #(
    parameter int DW_N    = 32,
    parameter int DW_D    = 22,
    parameter int QW      = 32,
    parameter int TIMEOUT = 63
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start0,
    input  logic [DW_N-1:0] dividend0,
    input  logic [DW_D-1:0] divisor0,
    input  logic            start1,
    input  logic [DW_N-1:0] dividend1,
    input  logic [DW_D-1:0] divisor1,
    output logic            busy0,
    output logic            busy1,
    output logic            ack0,
    output logic            ack1,
    output logic [QW-1:0]   quot0,
    output logic [QW-1:0]   quot1,
    output logic            err0,
    output logic            err1,
    output logic            div_start,
    output logic [DW_N-1:0] div_dividend,
    output logic [DW_D-1:0] div_divisor,
    input  logic [QW-1:0]   div_quotient,
    input  logic            div_qv
);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO = TW'(TIMEOUT);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]      state_q, state_d;
    logic            pend0_q, pend0_d, pend1_q, pend1_d;
    logic [DW_N-1:0] opn0_q, opn0_d, opn1_q, opn1_d;
    logic [DW_D-1:0] opd0_q, opd0_d, opd1_q, opd1_d;
    logic [DW_N-1:0] dvd_q, dvd_d;
    logic [DW_D-1:0] dvs_q, dvs_d;
    logic            id_q, id_d;
    logic            last_q, last_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [QW-1:0]   quot0_q, quot0_d, quot1_q, quot1_d;
    logic            err0_q, err0_d, err1_q, err1_d;

    logic            gnt1;
    logic [DW_D-1:0] sel_dvs;
    logic            res_we, res_id, res_err;
    logic [QW-1:0]   res_val;

    // Requester 1 wins only if 0 is idle or 0 was served last.
    assign gnt1    = pend1_q & (~pend0_q | ~last_q);
    assign sel_dvs = gnt1 ? opd1_q : opd0_q;

    always_comb begin
        state_d = state_q;
        pend0_d = pend0_q;
        pend1_d = pend1_q;
        opn0_d  = opn0_q;
        opn1_d  = opn1_q;
        opd0_d  = opd0_q;
        opd1_d  = opd1_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        id_d    = id_q;
        last_d  = last_q;
        timer_d = timer_q;
        quot0_d = quot0_q;
        quot1_d = quot1_q;
        err0_d  = err0_q;
        err1_d  = err1_q;
        res_we  = 1'b0;
        res_id  = id_q;
        res_err = 1'b0;
        res_val = '0;

        case (state_q)
            S_IDLE: begin
                if (pend0_q | pend1_q) begin
                    id_d  = gnt1;
                    dvd_d = gnt1 ? opn1_q : opn0_q;
                    dvs_d = sel_dvs;
                    if (gnt1) pend1_d = 1'b0;
                    else      pend0_d = 1'b0;
                    if (sel_dvs == '0) begin
                        res_we  = 1'b1;
                        res_id  = gnt1;
                        res_err = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                timer_d = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (div_qv) begin
                    res_we  = 1'b1;
                    res_val = div_quotient;
                    state_d = S_DONE;
                end else if (timer_q == TMO) begin
                    res_we  = 1'b1;
                    res_err = 1'b1;
                    state_d = S_DONE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: begin
                last_d  = id_q;
                state_d = S_IDLE;
            end
        endcase

        // Result registers change only on entry to DONE, so they hold until
        // the same requester's next ack.
        if (res_we) begin
            if (res_id) begin
                quot1_d = res_val;
                err1_d  = res_err;
            end else begin
                quot0_d = res_val;
                err0_d  = res_err;
            end
        end

        // Accept cannot collide with the grant clear: grant needs pending=1,
        // accept needs pending=0.
        if (start0 && !pend0_q) begin
            pend0_d = 1'b1;
            opn0_d  = dividend0;
            opd0_d  = divisor0;
        end
        if (start1 && !pend1_q) begin
            pend1_d = 1'b1;
            opn1_d  = dividend1;
            opd1_d  = divisor1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            pend0_q <= 1'b0;
            pend1_q <= 1'b0;
            opn0_q  <= '0;
            opn1_q  <= '0;
            opd0_q  <= '0;
            opd1_q  <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            id_q    <= 1'b0;
            last_q  <= 1'b1;
            timer_q <= '0;
            quot0_q <= '0;
            quot1_q <= '0;
            err0_q  <= 1'b0;
            err1_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pend0_q <= pend0_d;
            pend1_q <= pend1_d;
            opn0_q  <= opn0_d;
            opn1_q  <= opn1_d;
            opd0_q  <= opd0_d;
            opd1_q  <= opd1_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            id_q    <= id_d;
            last_q  <= last_d;
            timer_q <= timer_d;
            quot0_q <= quot0_d;
            quot1_q <= quot1_d;
            err0_q  <= err0_d;
            err1_q  <= err1_d;
        end
    end

    assign busy0        = pend0_q;
    assign busy1        = pend1_q;
    assign ack0         = (state_q == S_DONE) & ~id_q;
    assign ack1         = (state_q == S_DONE) &  id_q;
    assign quot0        = quot0_q;
    assign quot1        = quot1_q;
    assign err0         = err0_q;
    assign err1         = err1_q;
    assign div_start    = (state_q == S_ISSUE);
    assign div_dividend = dvd_q;
    assign div_divisor  = dvs_q;

endmodule

// File: tb/tb_div_share_sched.sv
module tb_div_share_sched;
    logic        clk = 1'b0;
    logic        rst;
    int          checks = 0;
    int          failures = 0;

    // main instance (TIMEOUT 63) with a latency-8 divider model
    logic        start0, start1;
    logic [31:0] dividend0, dividend1;
    logic [21:0] divisor0, divisor1;
    logic        busy0, busy1, ack0, ack1, err0, err1, div_start;
    logic [31:0] quot0, quot1, div_dividend;
    logic [21:0] div_divisor;
    logic [31:0] m_quot = '0;
    logic        m_qv = 1'b0;
    int          m_cnt = 0;

    // timeout instance (TIMEOUT 4) with a hand-driven divider side
    logic        t_start0;
    logic [31:0] t_dvd0;
    logic [21:0] t_dvs0;
    logic        t_start1 = 1'b0;
    logic [31:0] t_dvd1 = '0;
    logic [21:0] t_dvs1 = '0;
    logic        t_busy0, t_busy1, t_ack0, t_ack1, t_err0, t_err1, t_div_start;
    logic [31:0] t_quot0, t_quot1, t_div_dividend;
    logic [21:0] t_div_divisor;
    logic [31:0] t_quot = 32'hDEAD;
    logic        t_qv;

    always #5 clk = ~clk;

    div_share_sched u_dut (
        .clk(clk), .rst(rst),
        .start0(start0), .dividend0(dividend0), .divisor0(divisor0),
        .start1(start1), .dividend1(dividend1), .divisor1(divisor1),
        .busy0(busy0), .busy1(busy1), .ack0(ack0), .ack1(ack1),
        .quot0(quot0), .quot1(quot1), .err0(err0), .err1(err1),
        .div_start(div_start), .div_dividend(div_dividend), .div_divisor(div_divisor),
        .div_quotient(m_quot), .div_qv(m_qv)
    );

    div_share_sched #(.TIMEOUT(4)) u_dut_to (
        .clk(clk), .rst(rst),
        .start0(t_start0), .dividend0(t_dvd0), .divisor0(t_dvs0),
        .start1(t_start1), .dividend1(t_dvd1), .divisor1(t_dvs1),
        .busy0(t_busy0), .busy1(t_busy1), .ack0(t_ack0), .ack1(t_ack1),
        .quot0(t_quot0), .quot1(t_quot1), .err0(t_err0), .err1(t_err1),
        .div_start(t_div_start), .div_dividend(t_div_dividend), .div_divisor(t_div_divisor),
        .div_quotient(t_quot), .div_qv(t_qv)
    );

    // Divider model: qv exactly 8 cycles after the div_start cycle.
    always @(posedge clk) begin
        m_qv <= 1'b0;
        if (div_start) begin
            m_cnt <= 8;
        end else if (m_cnt != 0) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 2) begin
                m_qv   <= 1'b1;
                m_quot <= div_dividend / {10'd0, div_divisor};
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick();
        tick();
        checks++; if ({busy0, busy1, ack0, ack1, err0, err1, div_start} !== 7'b0) begin failures++; $display("FAIL reset_flags got=%b exp=0000000", {busy0, busy1, ack0, ack1, err0, err1, div_start}); end
        checks++; if ({quot0, quot1, div_dividend, div_divisor} !== '0) begin failures++; $display("FAIL reset_data got=%h exp=0", {quot0, quot1, div_dividend, div_divisor}); end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_both();
        int n;
        start0 = 1'b1; dividend0 = 640;  divisor0 = 64;
        start1 = 1'b1; dividend1 = 1280; divisor1 = 64;
        tick();
        start0 = 1'b0; start1 = 1'b0;
        checks++; if ({busy0, busy1} !== 2'b11) begin failures++; $display("FAIL both_busy got=%b exp=11", {busy0, busy1}); end
        tick();
        checks++; if (div_start !== 1'b1 || div_dividend !== 32'd640) begin failures++; $display("FAIL both_first_issue got=%b/%0d exp=1/640", div_start, div_dividend); end
        n = 0;
        while (ack0 !== 1'b1 && n < 30) begin tick(); n++; end
        checks++; if (n != 9 || quot0 !== 32'd10 || ack1 !== 1'b0) begin failures++; $display("FAIL both_ack0 got=n%0d q%0d a1=%b exp=n9 q10 a1=0", n, quot0, ack1); end
        tick();
        tick();
        checks++; if (div_start !== 1'b1 || div_dividend !== 32'd1280) begin failures++; $display("FAIL both_second_issue got=%b/%0d exp=1/1280", div_start, div_dividend); end
        n = 0;
        while (ack1 !== 1'b1 && n < 30) begin tick(); n++; end
        checks++; if (n != 9 || quot1 !== 32'd20 || err1 !== 1'b0 || quot0 !== 32'd10) begin failures++; $display("FAIL both_ack1 got=n%0d q1=%0d e1=%b q0=%0d exp=n9 20 0 10", n, quot1, err1, quot0); end
        tick();
        tick();
    endtask

    task automatic test_basic();
        int n;
        start0 = 1'b1; dividend0 = 1000; divisor0 = 10;
        tick();
        start0 = 1'b0;
        checks++; if (busy0 !== 1'b1 || div_start !== 1'b0) begin failures++; $display("FAIL basic_c1 got=busy%b ds%b exp=busy1 ds0", busy0, div_start); end
        tick();
        checks++; if (div_start !== 1'b1 || busy0 !== 1'b0 || div_dividend !== 32'd1000 || div_divisor !== 22'd10) begin failures++; $display("FAIL basic_issue got=%b %b %0d/%0d exp=1 0 1000/10", div_start, busy0, div_dividend, div_divisor); end
        n = 0;
        while (ack0 !== 1'b1 && n < 30) begin tick(); n++; end
        checks++; if (n != 9 || quot0 !== 32'd100 || err0 !== 1'b0) begin failures++; $display("FAIL basic_ack got=n%0d q%0d e%b exp=n9 q100 e0", n, quot0, err0); end
        tick();
        checks++; if (ack0 !== 1'b0 || quot0 !== 32'd100) begin failures++; $display("FAIL basic_hold got=a%b q%0d exp=a0 q100", ack0, quot0); end
        tick();
    endtask

    task automatic test_tie_rr();
        int n;
        start0 = 1'b1; dividend0 = 100; divisor0 = 4;
        start1 = 1'b1; dividend1 = 90;  divisor1 = 3;
        tick();
        start0 = 1'b0; start1 = 1'b0;
        tick();
        checks++; if (div_start !== 1'b1 || div_dividend !== 32'd90) begin failures++; $display("FAIL rr_first_is_1 got=%b/%0d exp=1/90", div_start, div_dividend); end
        n = 0;
        while (ack1 !== 1'b1 && n < 30) begin tick(); n++; end
        checks++; if (n != 9 || quot1 !== 32'd30) begin failures++; $display("FAIL rr_ack1 got=n%0d q%0d exp=n9 q30", n, quot1); end
        n = 0;
        while (ack0 !== 1'b1 && n < 30) begin tick(); n++; end
        checks++; if (n != 11 || quot0 !== 32'd25) begin failures++; $display("FAIL rr_ack0 got=n%0d q%0d exp=n11 q25", n, quot0); end
        tick();
        tick();
    endtask

    task automatic test_div0();
        logic saw_ds;
        start1 = 1'b1; dividend1 = 77; divisor1 = 0;
        saw_ds = div_start;
        tick();
        start1 = 1'b0;
        saw_ds = saw_ds | div_start;
        tick();
        checks++; if (ack1 !== 1'b1 || quot1 !== 32'd0 || err1 !== 1'b1) begin failures++; $display("FAIL div0_ack got=a%b q%0d e%b exp=a1 q0 e1", ack1, quot1, err1); end
        for (int i = 0; i < 4; i++) begin saw_ds = saw_ds | div_start; tick(); end
        checks++; if (saw_ds !== 1'b0 || ack1 !== 1'b0) begin failures++; $display("FAIL div0_no_start got=ds%b a%b exp=ds0 a0", saw_ds, ack1); end
    endtask

    task automatic test_requeue();
        int n;
        logic saw_ds;
        start0 = 1'b1; dividend0 = 600; divisor0 = 6;
        tick();
        start0 = 1'b0;
        tick();
        tick();
        start0 = 1'b1; dividend0 = 700; divisor0 = 5;
        tick();
        checks++; if (busy0 !== 1'b1) begin failures++; $display("FAIL requeue_busy got=%b exp=1", busy0); end
        start0 = 1'b1; dividend0 = 999; divisor0 = 3;
        tick();
        start0 = 1'b0;
        n = 0;
        while (ack0 !== 1'b1 && n < 30) begin tick(); n++; end
        checks++; if (n != 6 || quot0 !== 32'd100) begin failures++; $display("FAIL requeue_first got=n%0d q%0d exp=n6 q100", n, quot0); end
        tick();
        tick();
        checks++; if (div_start !== 1'b1 || div_dividend !== 32'd700 || div_divisor !== 22'd5) begin failures++; $display("FAIL requeue_ops got=%b %0d/%0d exp=1 700/5", div_start, div_dividend, div_divisor); end
        n = 0;
        while (ack0 !== 1'b1 && n < 30) begin tick(); n++; end
        checks++; if (n != 9 || quot0 !== 32'd140) begin failures++; $display("FAIL requeue_second got=n%0d q%0d exp=n9 q140", n, quot0); end
        saw_ds = 1'b0;
        for (int i = 0; i < 12; i++) begin tick(); saw_ds = saw_ds | div_start | busy0; end
        checks++; if (saw_ds !== 1'b0) begin failures++; $display("FAIL requeue_third_ignored got=%b exp=0", saw_ds); end
    endtask

    task automatic test_reset_mid();
        int n;
        logic saw;
        start0 = 1'b1; dividend0 = 500; divisor0 = 5;
        tick();
        start0 = 1'b0;
        tick();
        tick();
        start1 = 1'b1; dividend1 = 800; divisor1 = 8;
        tick();
        start1 = 1'b0;
        checks++; if (busy1 !== 1'b1) begin failures++; $display("FAIL rmid_busy1 got=%b exp=1", busy1); end
        rst = 1'b0;
        #1;
        checks++; if ({busy1, err1, quot0, div_dividend, div_divisor} !== '0) begin failures++; $display("FAIL rmid_async got=%b %b %0d %0d %0d exp=0", busy1, err1, quot0, div_dividend, div_divisor); end
        tick();
        rst = 1'b1;
        saw = 1'b0;
        for (int i = 0; i < 15; i++) begin tick(); saw = saw | ack0 | ack1 | div_start; end
        checks++; if (saw !== 1'b0) begin failures++; $display("FAIL rmid_no_ack got=%b exp=0", saw); end
        start0 = 1'b1; dividend0 = 300; divisor0 = 3;
        tick();
        start0 = 1'b0;
        tick();
        n = 0;
        while (ack0 !== 1'b1 && n < 30) begin tick(); n++; end
        checks++; if (n != 9 || quot0 !== 32'd100 || err0 !== 1'b0) begin failures++; $display("FAIL rmid_fresh got=n%0d q%0d e%b exp=n9 q100 e0", n, quot0, err0); end
        tick();
    endtask

    task automatic test_timeout();
        int c;
        logic saw;
        t_start0 = 1'b1; t_dvd0 = 50; t_dvs0 = 5;
        tick();
        t_start0 = 1'b0;
        tick();
        checks++; if (t_div_start !== 1'b1) begin failures++; $display("FAIL to_issue got=%b exp=1", t_div_start); end
        c = 2;
        while (t_ack0 !== 1'b1 && c < 30) begin tick(); c++; end
        checks++; if (c != 8 || t_err0 !== 1'b1 || t_quot0 !== 32'd0) begin failures++; $display("FAIL to_ack got=c%0d e%b q%0d exp=c8 e1 q0", c, t_err0, t_quot0); end
        tick();
        tick();
        t_qv = 1'b1;
        tick();
        t_qv = 1'b0;
        saw = 1'b0;
        for (int i = 0; i < 6; i++) begin saw = saw | t_ack0 | t_ack1; tick(); end
        checks++; if (saw !== 1'b0 || t_quot0 !== 32'd0 || t_err0 !== 1'b1) begin failures++; $display("FAIL to_late_qv got=a%b q%0d e%b exp=a0 q0 e1", saw, t_quot0, t_err0); end
    endtask

    initial begin
        start0 = 1'b0; start1 = 1'b0;
        dividend0 = '0; dividend1 = '0; divisor0 = '0; divisor1 = '0;
        t_start0 = 1'b0; t_dvd0 = '0; t_dvs0 = '0; t_qv = 1'b0;
        test_reset();
        test_both();
        test_basic();
        test_tie_rr();
        test_div0();
        test_requeue();
        test_reset_mid();
        test_timeout();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
